pipe_stage_skid: RTL

Parametrised elastic pipeline-stage register for inter-stage boundaries (D/X, X/M, M/W) of the processor pipeline. It carries a payload of data words, register specifiers and control bits from one stage to the next. A valid/ready handshake with a two-entry skid buffer lets a downstream stall propagate upstream one cycle later without dropping or duplicating an instruction. Flush inserts a bubble whose control bits read as zero, and a saturating stall counter supports performance debug.

---
 rtl/pipe_stage_skid_if.sv | 34 +++
 rtl/pipe_stage_skid.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake and payload bundle for one pipeline-stage boundary.
// The slave modport is the stage register's view. The master modport is the
// view of the environment that feeds the stage and consumes its output.
interface pipe_stage_skid_if #(
    parameter int DATA_W  = 32,
    parameter int N_WORDS = 2,
    parameter int REG_W   = 5,
    parameter int N_REGS  = 2,
    parameter int N_CTRL  = 3
);
    // Upstream side
    logic                      inValid;
    logic                      inReady;
    logic [N_WORDS*DATA_W-1:0] dataIn;
    logic [N_REGS*REG_W-1:0]   regIn;
    logic [N_CTRL-1:0]         ctrlIn;

    // Downstream side
    logic                      outValid;
    logic                      outReady;
    logic [N_WORDS*DATA_W-1:0] dataOut;
    logic [N_REGS*REG_W-1:0]   regOut;
    logic [N_CTRL-1:0]         ctrlOut;

    modport slave (
        input  inValid, dataIn, regIn, ctrlIn, outReady,
        output inReady, outValid, dataOut, regOut, ctrlOut
    );

    modport master (
        output inValid, dataIn, regIn, ctrlIn, outReady,
        input  inReady, outValid, dataOut, regOut, ctrlOut
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// The main entry drives the outputs. The skid entry catches the one payload
// that can arrive in the cycle after downstream stalls. inReady is taken from
// registered state only, so outReady has no combinational path to upstream.
module pipe_stage_skid #(
    parameter int DATA_W  = 32,
    parameter int N_WORDS = 2,
    parameter int REG_W   = 5,
    parameter int N_REGS  = 2,
    parameter int N_CTRL  = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_skid_if.slave bus,
    output logic [CNT_W-1:0] stallCount
);
    localparam int DW = N_WORDS * DATA_W;
    localparam int RW = N_REGS * REG_W;

    // Occupancy is fully described by the two valid bits, encoded as a state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DW-1:0]     r_main_data;
    logic [RW-1:0]     r_main_regs;
    logic [N_CTRL-1:0] r_main_ctrl;
    logic [DW-1:0]     r_skid_data;
    logic [RW-1:0]     r_skid_regs;
    logic [N_CTRL-1:0] r_skid_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic          w_out_valid;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_drain;
    logic          w_load_main;
    logic          w_main_from_skid;
    logic          w_load_skid;
    logic [DW-1:0] w_main_data_next;

    assign w_accept = bus.inValid & w_in_ready;
    assign w_drain  = w_out_valid & bus.outReady;

    // Main-entry data source, selected word by word: the skid entry when it
    // is promoted, otherwise the incoming payload.
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_main_word
        assign w_main_data_next[gi*DATA_W +: DATA_W] = w_main_from_skid
            ? r_skid_data[gi*DATA_W +: DATA_W]
            : bus.dataIn[gi*DATA_W +: DATA_W];
    end

    // State register: reset beats flush, and flush beats the handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and payload-load decode from the accept/drain pair.
    always_comb begin
        w_state_next     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_main  = 1'b1;
                    w_state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_load_skid  = 1'b1;
                    w_state_next = ST_FULL;
                end else if (w_drain) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_next     = ST_ONE;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
        // A flush empties the stage. Whatever was accepted this cycle is dropped.
        if (flush) begin
            w_state_next = ST_EMPTY;
        end
    end

    // Handshake outputs from the registered state; ctrl is masked while idle.
    always_comb begin
        w_out_valid  = (r_state != ST_EMPTY);
        w_in_ready   = (r_state != ST_FULL);
        bus.outValid = w_out_valid;
        bus.inReady  = w_in_ready;
        bus.dataOut  = r_main_data;
        bus.regOut   = r_main_regs;
        bus.ctrlOut  = w_out_valid ? r_main_ctrl : '0;
    end

    // Payload registers for main and skid entries. Loads are suppressed
    // during flush, so the entries keep stale but harmless contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_main_data <= '0;
            r_main_regs <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_regs <= '0;
            r_skid_ctrl <= '0;
        end else if (!flush) begin
            if (w_load_main) begin
                r_main_data <= w_main_data_next;
                r_main_regs <= w_main_from_skid ? r_skid_regs : bus.regIn;
                r_main_ctrl <= w_main_from_skid ? r_skid_ctrl : bus.ctrlIn;
            end
            if (w_load_skid) begin
                r_skid_data <= bus.dataIn;
                r_skid_regs <= bus.regIn;
                r_skid_ctrl <= bus.ctrlIn;
            end
        end
    end

    // Saturating count of cycles where downstream refuses a valid output.
    // Only reset clears it, so it survives flushes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !bus.outReady && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stallCount = r_stall_cnt;

endmodule
